fir_axilite_cfg: RTL and testbench

AXI-Lite responder (slave) for the FIR accelerator's configuration space; it answers the host's write/read transactions. Holds the ap_ctrl block-control register and the data_length register. Owns the tap-coefficient BRAM port and shares it between the host (while idle) and the FIR datapath engine (while running). Sits between the AXI-Lite bus and the fir engine / tap bram11 instance.

---
 rtl/fir_axilite_cfg.sv | 191 +++++++++++++++++++
 tb/tb_fir_axilite_cfg.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axilite_cfg.sv
`default_nettype none
// ============================================================================
// Module   : fir_axilite_cfg
// Brief    : AXI-Lite configuration responder for the FIR accelerator; holds
//            ap_ctrl / data_length and arbitrates the tap BRAM port.
// Revision : 1.0 - initial release
// ============================================================================
module fir_axilite_cfg #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic                   eng_tap_EN,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic                   ap_start_pulse,
  output logic [31:0]            data_length,
  input  logic                   eng_done
);

  localparam logic [pADDR_WIDTH-1:0] c_ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] c_ADDR_LEN  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] c_ADDR_TAP  = pADDR_WIDTH'(32'h20);
  localparam logic [pADDR_WIDTH-1:0] c_TAP_END   = pADDR_WIDTH'(32'h20 + 4 * Tape_Num);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_RESP = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_RESP = 2'd3
  } state_t;

  state_t                   r_state;
  logic                     r_awready;
  logic                     r_wready;
  logic                     r_arready;
  logic                     r_rvalid;
  logic [pDATA_WIDTH-1:0]   r_rdata;
  logic [pADDR_WIDTH-1:0]   r_raddr;
  logic                     r_rd_owned;
  logic                     r_host_tap_en;
  logic [3:0]               r_host_tap_we;
  logic [pADDR_WIDTH-1:0]   r_host_tap_a;
  logic [pDATA_WIDTH-1:0]   r_host_tap_di;
  logic                     r_start_pulse;
  logic                     r_ap_done;
  logic                     r_ap_idle;
  logic [31:0]              r_data_length;
  logic [pDATA_WIDTH-1:0]   w_rd_value;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= c_ADDR_TAP) && (a < c_TAP_END) && (a[1:0] == 2'b00);
  endfunction

  // Read mux: a tap read issued while the engine owned the BRAM returns all ones.
  always_comb begin
    w_rd_value = '0;
    if (r_raddr == c_ADDR_CTRL) begin
      w_rd_value[2:0] = {r_ap_idle, r_ap_done, r_start_pulse};
    end else if (r_raddr == c_ADDR_LEN) begin
      w_rd_value = pDATA_WIDTH'(r_data_length);
    end else if (is_tap(r_raddr)) begin
      w_rd_value = r_rd_owned ? tap_Do : '1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state       <= S_IDLE;
      r_awready     <= 1'b0;
      r_wready      <= 1'b0;
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_raddr       <= '0;
      r_rd_owned    <= 1'b0;
      r_host_tap_en <= 1'b0;
      r_host_tap_we <= 4'h0;
      r_host_tap_a  <= '0;
      r_host_tap_di <= '0;
      r_start_pulse <= 1'b0;
      r_ap_done     <= 1'b0;
      r_ap_idle     <= 1'b1;
      r_data_length <= '0;
    end else begin
      r_start_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_awready) begin
            // Handshake cycle: the host BRAM strobe registered last cycle is live now.
            r_awready     <= 1'b0;
            r_wready      <= 1'b0;
            r_host_tap_en <= 1'b0;
            r_host_tap_we <= 4'h0;
            r_host_tap_a  <= '0;
            r_host_tap_di <= '0;
            if ((awaddr == c_ADDR_CTRL) && wdata[0] && r_ap_idle) begin
              r_start_pulse <= 1'b1;
              r_ap_idle     <= 1'b0;
            end
            if ((awaddr == c_ADDR_LEN) && r_ap_idle) begin
              r_data_length <= 32'(wdata);
            end
            r_state <= S_WR_RESP;
          end else if (r_arready) begin
            r_arready     <= 1'b0;
            r_raddr       <= araddr;
            r_host_tap_en <= 1'b0;
            r_host_tap_a  <= '0;
            r_state       <= S_RD_WAIT;
          end else if (awvalid && wvalid) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            if (is_tap(awaddr) && r_ap_idle) begin
              r_host_tap_en <= 1'b1;
              r_host_tap_we <= 4'hF;
              r_host_tap_a  <= awaddr - c_ADDR_TAP;
              r_host_tap_di <= wdata;
            end
          end else if (arvalid) begin
            r_arready  <= 1'b1;
            r_rd_owned <= r_ap_idle;
            if (is_tap(araddr) && r_ap_idle) begin
              r_host_tap_en <= 1'b1;
              r_host_tap_a  <= araddr - c_ADDR_TAP;
            end
          end
        end
        S_WR_RESP: begin
          r_state <= S_IDLE;
        end
        S_RD_WAIT: begin
          r_rvalid <= 1'b1;
          r_rdata  <= w_rd_value;
          r_state  <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (rready) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
            if (r_raddr == c_ADDR_CTRL) begin
              r_ap_done <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // Placed last so a completion beats a same-cycle clear-on-read.
      if (eng_done) begin
        r_ap_done <= 1'b1;
        r_ap_idle <= 1'b1;
      end
    end
  end

  assign awready        = r_awready;
  assign wready         = r_wready;
  assign arready        = r_arready;
  assign rvalid         = r_rvalid;
  assign rdata          = r_rdata;
  assign ap_start_pulse = r_start_pulse;
  assign data_length    = r_data_length;

  // The engine owns the tap port whenever the block is not idle.
  assign tap_EN = r_ap_idle ? r_host_tap_en : eng_tap_EN;
  assign tap_A  = r_ap_idle ? r_host_tap_a  : eng_tap_A;
  assign tap_WE = r_ap_idle ? r_host_tap_we : 4'h0;
  assign tap_Di = r_host_tap_di;

endmodule
`default_nettype wire

// File: tb/tb_fir_axilite_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_axilite_cfg
// Brief    : Directed self-checking bench for fir_axilite_cfg with a register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_axilite_cfg;
  localparam int NT = 11;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, rvalid;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di, tap_Do;
  logic [11:0] tap_A;
  logic        eng_tap_EN = 1'b0;
  logic [11:0] eng_tap_A = '0;
  logic        ap_start_pulse;
  logic [31:0] data_length;
  logic        eng_done = 1'b0;

  fir_axilite_cfg #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(NT)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .eng_tap_EN(eng_tap_EN), .eng_tap_A(eng_tap_A),
    .ap_start_pulse(ap_start_pulse), .data_length(data_length), .eng_done(eng_done)
  );

  always #5 axis_clk = ~axis_clk;

  // Stand-in tap BRAM with one cycle read latency.
  logic [31:0] bram [0:1023];
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) bram[tap_A[11:2]][b*8 +: 8] <= tap_Di[b*8 +: 8];
      tap_Do <= bram[tap_A[11:2]];
    end
  end

  int total = 0;
  int bad = 0;

  // Register-map model
  logic [31:0] m_taps [NT];
  logic [31:0] m_len;
  logic        m_idle, m_done;
  logic [31:0] exp_q [$];
  logic        checks_on = 1'b0;
  logic [11:0] hs_tap_A;
  logic [3:0]  hs_tap_WE;
  logic [31:0] hs_tap_Di;
  int          coef [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_tap_addr(input logic [11:0] a);
    return (a >= 12'h20) && (a < 12'(32'h20 + 4 * NT)) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == 12'h00) return {29'b0, m_idle, m_done, 1'b0};
    if (a == 12'h10) return m_len;
    if (is_tap_addr(a)) return m_idle ? m_taps[(a - 12'h20) >> 2] : 32'hFFFF_FFFF;
    return 32'h0;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    if (a == 12'h00 && d[0] && m_idle) m_idle = 1'b0;
    else if (a == 12'h10 && m_idle) m_len = d;
    else if (is_tap_addr(a) && m_idle) m_taps[(a - 12'h20) >> 2] = d;
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    m_done = 1'b0;
    m_len  = '0;
    exp_q.delete();
  endtask

  always @(negedge axis_clk) begin
    if (checks_on) begin
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rdata_unexpected: got %h expected no response", rdata);
        end else begin
          check("rdata", rdata, exp_q.pop_front());
        end
      end
      check("data_length", data_length, m_len);
      if (!m_idle) begin
        check("tap_WE_busy", {28'b0, tap_WE}, 32'h0);
        check("tap_A_busy", 32'(tap_A), 32'(eng_tap_A));
        check("tap_EN_busy", {31'b0, tap_EN}, {31'b0, eng_tap_EN});
      end
    end
  end

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge axis_clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
    do begin
      @(negedge axis_clk);
      n++;
    end while (!(awready && wready) && n < 50);
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL write_timeout: addr %h got no awready expected awready=1", a);
    end
    hs_tap_A = tap_A; hs_tap_WE = tap_WE; hs_tap_Di = tap_Di;
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(a, d);
  endtask

  task automatic axi_read(input logic [11:0] a, input int hold, output logic [31:0] d);
    int n = 0;
    @(negedge axis_clk);
    arvalid = 1'b1; araddr = a;
    do begin
      @(negedge axis_clk);
      n++;
    end while (!arready && n < 50);
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL read_ar_timeout: addr %h got no arready expected arready=1", a);
    end
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    exp_q.push_back(model_read(a));
    n = 0;
    do begin
      @(negedge axis_clk);
      n++;
    end while (!rvalid && n < 50);
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL read_r_timeout: addr %h got no rvalid expected rvalid=1", a);
    end
    d = rdata;
    if (hold > 0) begin
      arvalid = 1'b1; araddr = 12'h10;
      for (int i = 0; i < hold; i++) begin
        @(negedge axis_clk);
        check("rvalid_hold", {31'b0, rvalid}, 32'h1);
        check("rdata_hold", rdata, d);
        check("arready_blocked", {31'b0, arready}, 32'h0);
      end
      arvalid = 1'b0;
    end
    @(posedge axis_clk); #1;
    rready = 1'b1;
    @(posedge axis_clk); #1;
    rready = 1'b0;
    if (a == 12'h00) m_done = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    model_reset();
    for (int k = 0; k < NT; k++) m_taps[k] = '0;
    repeat (2) @(negedge axis_clk);
    check("rst_readies", {28'b0, awready, wready, arready, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_tap", {tap_WE, tap_EN, 27'b0}, 32'h0);
    check("rst_tap_A_Di", tap_Di | 32'(tap_A), 32'h0);
    check("rst_start_len", data_length | {31'b0, ap_start_pulse}, 32'h0);
    @(posedge axis_clk); #1;
    axis_rst_n = 1'b1;
    checks_on  = 1'b1;
    repeat (3) begin
      @(negedge axis_clk);
      check("quiet_readies", {28'b0, awready, wready, arready, rvalid}, 32'h0);
    end

    axi_read(12'h00, 0, d); check("ctrl_after_reset", d, 32'h4);
    axi_read(12'h10, 0, d); check("len_after_reset", d, 32'h0);

    axi_write(12'h10, 32'd600);
    for (int k = 0; k < NT; k++) begin
      axi_write(12'(32'h20 + 4 * k), 32'(coef[k]));
      if (k == 4) begin
        check("wr30_tap_A", 32'(hs_tap_A), 32'h10);
        check("wr30_tap_WE", {28'b0, hs_tap_WE}, 32'hF);
        check("wr30_tap_Di", hs_tap_Di, 32'd56);
      end
    end
    for (int k = 0; k < NT; k++) begin
      axi_read(12'(32'h20 + 4 * k), 0, d);
      check("tap_readback", d, 32'(coef[k]));
    end
    axi_read(12'h10, 0, d); check("len_600", d, 32'd600);

    eng_tap_EN = 1'b1; eng_tap_A = 12'h008;
    axi_write(12'h00, 32'h1);
    check("start_pulse_on", {31'b0, ap_start_pulse}, 32'h1);
    @(posedge axis_clk); #1;
    check("start_pulse_off", {31'b0, ap_start_pulse}, 32'h0);
    axi_read(12'h00, 0, d); check("ctrl_busy", d & 32'h7, 32'h0);
    eng_tap_A = 12'h01C;

    axi_write(12'h24, 32'd99);
    axi_read(12'h24, 0, d); check("tap_read_busy", d, 32'hFFFF_FFFF);
    axi_write(12'h10, 32'd5);
    check("len_locked", data_length, 32'd600);
    axi_write(12'h00, 32'h1);
    check("start_ignored_busy", {31'b0, ap_start_pulse}, 32'h0);

    @(negedge axis_clk);
    eng_done = 1'b1;
    @(posedge axis_clk); #1;
    eng_done = 1'b0; eng_tap_EN = 1'b0;
    m_done = 1'b1; m_idle = 1'b1;
    axi_read(12'h00, 0, d); check("ctrl_done", d, 32'h6);
    axi_read(12'h00, 0, d); check("ctrl_done_cleared", d, 32'h4);
    axi_read(12'h24, 0, d); check("tap_write_dropped", d, 32'hFFFF_FFF6);

    axi_read(12'h10, 5, d); check("hold_read", d, 32'd600);
    axi_write(12'h4C, 32'hDEAD_BEEF);
    axi_read(12'h4C, 0, d); check("unmapped_read", d, 32'h0);
    axi_read(12'h14, 0, d); check("unmapped_14", d, 32'h0);

    // Reset while a read response is in flight.
    @(negedge axis_clk);
    arvalid = 1'b1; araddr = 12'h10;
    @(negedge axis_clk);
    @(negedge axis_clk);
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    checks_on = 1'b0;
    axis_rst_n = 1'b0;
    #1;
    check("midrst_rvalid", {31'b0, rvalid}, 32'h0);
    check("midrst_arready", {31'b0, arready}, 32'h0);
    check("midrst_len", data_length, 32'h0);
    model_reset();
    @(posedge axis_clk); #1;
    axis_rst_n = 1'b1;
    checks_on  = 1'b1;
    axi_read(12'h00, 0, d); check("ctrl_after_midrst", d, 32'h4);

    repeat (2) @(posedge axis_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation reached time limit expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
